port_serializer: RTL and testbench
==================================

# port_serializer

Serial transmitter sitting between one mem_mesh output port and a single chip output pin. Where the pin-side filter turns pin activity into port words, this block turns port words into a timed pin waveform: each word written by the mesh is framed (start bit, DATA_WIDTH data bits LSB first, stop bit) and shifted out at a programmable bit period. It includes a one-word holding buffer, and reports frame completion back to the mesh as a single-cycle port event carrying a status word.

## Interface
Parameters:
- DATA_WIDTH, default 16: mesh port word width; also the number of data bits per frame.
- DIV_WIDTH, default 16: bit-period divisor width; must be ≤ DATA_WIDTH.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- port_active_out  input  1  data port write strobe from mesh; one word per high cycle.
- port_data_out  input  DATA_WIDTH  word to transmit.
- cfg_active  input  1  config port write strobe from mesh.
- cfg_data  input  DATA_WIDTH  config word; bits [DIV_WIDTH-1:0] give the divisor.
- port_active_in  output  1  completion event to mesh; single-cycle pulse.
- port_data_in  output  DATA_WIDTH  status word; valid whenever port_active_in is high.
- pin_out  output  1  serial line, registered; idle level 1.

## Operation
- Registers: div (DIV_WIDTH), hold (DATA_WIDTH) with hold_full, shift (DATA_WIDTH), bit timer (DIV_WIDTH), bit index, frame count (DATA_WIDTH-2 bits), sticky overflow flag.
- Bit period is div+1 cycles. div=0 gives 1 cycle per bit.
- FSM states and pin level:
  - IDLE: pin_out=1.
  - START: pin_out=0.
  - DATA: pin_out=shift[0]. shift moves right one bit at each bit boundary.
  - STOP: pin_out=1.
- Transitions:
  - IDLE → START when hold_full. hold moves to shift and hold_full clears in the same edge.
  - START → DATA after one bit period.
  - DATA → STOP after DATA_WIDTH bit periods.
  - At the end of STOP: if hold_full, go straight to START and reload shift from hold, with no idle gap. Otherwise go to IDLE.
- Data write, port_active_out=1:
  - If hold is empty, or is being emptied into shift on the same edge, the word is stored and hold_full is set.
  - Otherwise the word is dropped and overflow is set.
- Config write, cfg_active=1:
  - div is loaded from cfg_data[DIV_WIDTH-1:0] and overflow is cleared.
  - A write mid-frame takes effect at the next bit-timer reload. The bit currently in progress keeps its length.
  - If config and data writes coincide, both take effect. If that data write overflows, overflow is set, i.e. set wins over clear.
- Completion: at the edge ending a STOP bit, frame count increments (mod 2^(DATA_WIDTH-2)) and port_active_in is high for the following cycle.
- Status word: port_data_in = {overflow, hold_full, frame_count}, all sampled after that edge. port_data_in holds its value between pulses.
- Reset (asserted at any time, including mid-frame) forces, asynchronously:
  - state IDLE, pin_out=1, hold_full=0, overflow=0, frame count 0, div 0;
  - port_active_in=0 and port_data_in=0.
  - An in-flight frame is abandoned and produces no completion pulse.

## Timing
- Write sampled at edge T into an empty hold in IDLE:
  - START begins at edge T+1 and pin_out falls after T+1.
  - Each bit lasts exactly div+1 cycles.
  - The frame spans (DATA_WIDTH+2)·(div+1) cycles from edge T+1.
  - port_active_in is high for the single cycle after the final STOP edge.
- Back-to-back frames: the next START follows the previous STOP directly, with no IDLE cycle. port_active_in still pulses for the finished frame.
- A write is accepted in any state while hold is empty. At most two words are in flight: shift and hold.
- port_active_in never stays high for two consecutive cycles except with div=0 and back-to-back frames; that is impossible, since frames are ≥ DATA_WIDTH+2 cycles long.

## Test plan
- Reset, then cfg div=3, write 0xA5C3 (DATA_WIDTH=16):
  - pin_out=0 for 4 cycles, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB first) at 4 cycles each, then 1 for 4 cycles;
  - port_active_in pulses 72 cycles after START entry with port_data_in=0x0001.
- div=0, write 0x0001 then 0xFFFF three cycles later:
  - the second frame's START immediately follows the first STOP;
  - two completion pulses 18 cycles apart, counts 1 and 2, hold_full=0 in both.
- Three writes on consecutive cycles in IDLE:
  - words 1 and 2 are transmitted; word 3 is dropped;
  - the first completion shows overflow=1, i.e. port_data_in bit 15 set.
  - A cfg write afterwards clears overflow: the next completion has bit 15=0.
- cfg write div=7 in the middle of the third data bit at div=1:
  - the current bit keeps 2 cycles; subsequent bits are 8 cycles.
- rst_n low mid-DATA:
  - pin_out=1 and port_active_in=0 immediately, no clock needed;
  - after release, an idle line with no pulse; a new write produces a frame with frame count 1.

Source files
------------

// File: rtl/port_serializer_if.sv
// port_serializer_if: mesh-side data, config and completion signals of the serializer
interface port_serializer_if #(parameter int DATA_WIDTH = 16);
  logic                  port_active_out;
  logic [DATA_WIDTH-1:0] port_data_out;
  logic                  cfg_active;
  logic [DATA_WIDTH-1:0] cfg_data;
  logic                  port_active_in;
  logic [DATA_WIDTH-1:0] port_data_in;
  modport master (output port_active_out, port_data_out, cfg_active, cfg_data,
                  input  port_active_in, port_data_in);
  modport slave  (input  port_active_out, port_data_out, cfg_active, cfg_data,
                  output port_active_in, port_data_in);
endinterface

// File: rtl/port_serializer.sv
// port_serializer: frames mesh words (start, LSB-first data, stop) onto a pin at a programmable bit period
module port_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  port_serializer_if.slave bus,
  output logic             pin_out
);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d, timer_q, timer_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, shift_q, shift_d, stat_q, stat_d;
  logic [DATA_WIDTH-3:0] cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  hold_full_q, hold_full_d, ovf_q, ovf_d, pin_q, pin_d, act_q, act_d;
  logic                  tick, last, load, done, accept;
  // next-state: bit timer, framing FSM, holding buffer and status
  always_comb begin
    tick        = timer_q == '0;
    last        = bit_q == BW'(DATA_WIDTH - 1);
    done        = state_q == STOP && tick;
    load        = hold_full_q && (state_q == IDLE || done);
    accept      = bus.port_active_out && (!hold_full_q || load);
    state_d     = state_q == IDLE  ? (hold_full_q ? START : IDLE) :
                  state_q == START ? (tick ? DATA : START) :
                  state_q == DATA  ? (tick && last ? STOP : DATA) :
                                     (tick ? (hold_full_q ? START : IDLE) : STOP);
    timer_d     = (state_q == IDLE || tick) ? div_q : timer_q - 1'b1;
    bit_d       = state_q == START ? '0 : (state_q == DATA && tick) ? bit_q + 1'b1 : bit_q;
    shift_d     = load ? hold_q : (state_q == DATA && tick) ? shift_q >> 1 : shift_q;
    hold_d      = accept ? bus.port_data_out : hold_q;
    hold_full_d = accept ? 1'b1 : load ? 1'b0 : hold_full_q;
    ovf_d       = (bus.port_active_out && !accept) ? 1'b1 : bus.cfg_active ? 1'b0 : ovf_q;
    div_d       = bus.cfg_active ? bus.cfg_data[DIV_WIDTH-1:0] : div_q;
    cnt_d       = done ? cnt_q + 1'b1 : cnt_q;
    act_d       = done;
    stat_d      = done ? {ovf_d, hold_full_d, cnt_d} : stat_q;
    pin_d       = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  // state and registered outputs; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      timer_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      pin_q       <= 1'b1;
      act_q       <= 1'b0;
      stat_q      <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      timer_q     <= timer_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      pin_q       <= pin_d;
      act_q       <= act_d;
      stat_q      <= stat_d;
    end
  end
  assign pin_out            = pin_q;
  assign bus.port_active_in = act_q;
  assign bus.port_data_in   = stat_q;
endmodule

// File: tb/tb_port_serializer.sv
// tb_port_serializer: directed checks of framing, timing, buffering, overflow and reset
module tb_port_serializer;
  logic clk = 1'b0, rst_n = 1'b0, pin_out;
  int errors = 0, checks = 0;
  port_serializer_if #(.DATA_WIDTH(16)) bus ();
  port_serializer #(.DATA_WIDTH(16), .DIV_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .pin_out(pin_out));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic wr(input logic [15:0] w);
    bus.port_active_out = 1'b1; bus.port_data_out = w;
    tick();
    bus.port_active_out = 1'b0;
  endtask
  task automatic cfg(input logic [15:0] d);
    bus.cfg_active = 1'b1; bus.cfg_data = d;
    tick();
    bus.cfg_active = 1'b0;
  endtask
  task automatic test_reset();
    tick();
    checks++; if (pin_out !== 1'b1) begin errors++; $display("FAIL reset_pin got=%b exp=1", pin_out); end
    checks++; if (bus.port_active_in !== 1'b0) begin errors++; $display("FAIL reset_act got=%b exp=0", bus.port_active_in); end
    checks++; if (bus.port_data_in !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", bus.port_data_in); end
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_frame();
    logic [15:0] w = 16'hA5C3;
    logic e;
    int bad = 0;
    do_reset();
    cfg(16'd3);
    wr(w);
    for (int k = 0; k < 72; k++) begin
      tick();
      e = (k / 4 == 0) ? 1'b0 : (k / 4 == 17) ? 1'b1 : w[k/4-1];
      if (pin_out !== e || bus.port_active_in !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL frame_wave bad_cycles=%0d exp=0", bad); end
    tick();
    checks++; if (bus.port_active_in !== 1'b1) begin errors++; $display("FAIL frame_pulse got=%b exp=1", bus.port_active_in); end
    checks++; if (bus.port_data_in !== 16'h0001) begin errors++; $display("FAIL frame_status got=%h exp=0001", bus.port_data_in); end
    checks++; if (pin_out !== 1'b1) begin errors++; $display("FAIL frame_idle got=%b exp=1", pin_out); end
    tick();
    checks++; if (bus.port_active_in !== 1'b0) begin errors++; $display("FAIL frame_pulse_len got=%b exp=0", bus.port_active_in); end
    checks++; if (bus.port_data_in !== 16'h0001) begin errors++; $display("FAIL frame_status_hold got=%h exp=0001", bus.port_data_in); end
  endtask
  task automatic test_back_to_back();
    int n = 0;
    int t[2];
    logic [15:0] d[2];
    do_reset();
    wr(16'h0001);
    tick(); tick();
    wr(16'hFFFF);
    for (int i = 4; i <= 45; i++) begin
      tick();
      if (bus.port_active_in === 1'b1) begin
        if (n < 2) begin t[n] = i; d[n] = bus.port_data_in; end
        n++;
      end
      if (i == 18) begin
        checks++; if (pin_out !== 1'b1) begin errors++; $display("FAIL b2b_stop got=%b exp=1", pin_out); end
      end
      if (i == 19) begin
        checks++; if (pin_out !== 1'b0) begin errors++; $display("FAIL b2b_no_gap got=%b exp=0", pin_out); end
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_npulse got=%0d exp=2", n); end
    if (n >= 2) begin
      checks++; if (t[0] != 19 || t[1] != 37) begin errors++; $display("FAIL b2b_timing got=%0d,%0d exp=19,37", t[0], t[1]); end
      checks++; if (d[0] !== 16'h0001) begin errors++; $display("FAIL b2b_status1 got=%h exp=0001", d[0]); end
      checks++; if (d[1] !== 16'h0002) begin errors++; $display("FAIL b2b_status2 got=%h exp=0002", d[1]); end
    end
  endtask
  task automatic test_overflow();
    logic [15:0] r1 = '0, r2 = '0;
    logic [15:0] d[2];
    int n = 0;
    do_reset();
    bus.port_active_out = 1'b1;
    bus.port_data_out = 16'h0003; tick();
    bus.port_data_out = 16'h00F0; tick();
    bus.port_data_out = 16'hFFFF; tick();
    bus.port_active_out = 1'b0;
    for (int i = 2; i <= 45; i++) begin
      if (i >= 2 && i <= 17) r1[i-2] = pin_out;
      if (i >= 20 && i <= 35) r2[i-20] = pin_out;
      if (bus.port_active_in === 1'b1) begin
        if (n < 2) d[n] = bus.port_data_in;
        n++;
      end
      bus.cfg_active = (i == 25); bus.cfg_data = 16'h0000;
      tick();
    end
    bus.cfg_active = 1'b0;
    checks++; if (r1 !== 16'h0003) begin errors++; $display("FAIL ovf_word1 got=%h exp=0003", r1); end
    checks++; if (r2 !== 16'h00F0) begin errors++; $display("FAIL ovf_word2 got=%h exp=00f0", r2); end
    checks++; if (n != 2) begin errors++; $display("FAIL ovf_npulse got=%0d exp=2", n); end
    if (n >= 2) begin
      checks++; if (d[0] !== 16'h8001) begin errors++; $display("FAIL ovf_status1 got=%h exp=8001", d[0]); end
      checks++; if (d[1] !== 16'h0002) begin errors++; $display("FAIL ovf_status2 got=%h exp=0002", d[1]); end
    end
    checks++; if (pin_out !== 1'b1 || bus.port_active_in !== 1'b0) begin errors++; $display("FAIL ovf_word3_dropped pin=%b act=%b exp=1,0", pin_out, bus.port_active_in); end
  endtask
  task automatic test_cfg_mid();
    do_reset();
    cfg(16'd1);
    wr(16'h5555);
    for (int i = 1; i <= 25; i++) begin
      bus.cfg_active = (i == 8); bus.cfg_data = 16'd7;
      tick();
      if (i == 8)  begin checks++; if (pin_out !== 1'b1) begin errors++; $display("FAIL cfgmid_bit2_end got=%b exp=1", pin_out); end end
      if (i == 9)  begin checks++; if (pin_out !== 1'b0) begin errors++; $display("FAIL cfgmid_bit3_start got=%b exp=0", pin_out); end end
      if (i == 16) begin checks++; if (pin_out !== 1'b0) begin errors++; $display("FAIL cfgmid_bit3_end got=%b exp=0", pin_out); end end
      if (i == 17) begin checks++; if (pin_out !== 1'b1) begin errors++; $display("FAIL cfgmid_bit4_start got=%b exp=1", pin_out); end end
      if (i == 24) begin checks++; if (pin_out !== 1'b1) begin errors++; $display("FAIL cfgmid_bit4_end got=%b exp=1", pin_out); end end
      if (i == 25) begin checks++; if (pin_out !== 1'b0) begin errors++; $display("FAIL cfgmid_bit5_start got=%b exp=0", pin_out); end end
    end
    bus.cfg_active = 1'b0;
  endtask
  task automatic test_reset_mid();
    int bad = 0;
    do_reset();
    wr(16'h0000);
    for (int i = 0; i < 20; i++) tick();
    wr(16'h0000);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (pin_out !== 1'b0 || bus.port_data_in !== 16'h0001) begin errors++; $display("FAIL rstmid_pre pin=%b data=%h exp=0,0001", pin_out, bus.port_data_in); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pin_out !== 1'b1) begin errors++; $display("FAIL rstmid_pin got=%b exp=1", pin_out); end
    checks++; if (bus.port_active_in !== 1'b0) begin errors++; $display("FAIL rstmid_act got=%b exp=0", bus.port_active_in); end
    checks++; if (bus.port_data_in !== 16'h0000) begin errors++; $display("FAIL rstmid_data got=%h exp=0000", bus.port_data_in); end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pin_out !== 1'b1 || bus.port_active_in !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_idle bad_cycles=%0d exp=0", bad); end
    wr(16'h00FF);
    for (int i = 0; i < 19; i++) tick();
    checks++; if (bus.port_active_in !== 1'b1 || bus.port_data_in !== 16'h0001) begin errors++; $display("FAIL rstmid_new act=%b data=%h exp=1,0001", bus.port_active_in, bus.port_data_in); end
  endtask
  initial begin
    bus.port_active_out = 1'b0; bus.port_data_out = '0;
    bus.cfg_active = 1'b0; bus.cfg_data = '0;
    test_reset();
    test_frame();
    test_back_to_back();
    test_overflow();
    test_cfg_mid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
